seq_bit_serializer: RTL and testbench

//   Upstream feeder for the double-sequence detector. Accepts parallel words over a valid/ready

---
 rtl/seq_bit_serializer_pkg.sv | 15 +
 rtl/seq_bit_serializer_skid.sv | 49 ++++
 rtl/seq_bit_serializer.sv | 116 +++++++++++
 tb/tb_seq_bit_serializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_bit_serializer_pkg.sv
// Shared definitions for the serializer feeding the double-sequence detector.
//   DSDO_WORD_W : default parallel word width
//   HOLD_ACTIVE : level on HOLD/EN that freezes the detector
//   len_w()     : width of a length field able to hold 0..w
package dsdo_pkg;

    localparam int DSDO_WORD_W = 8;

    localparam logic HOLD_ACTIVE = 1'b1;

    function automatic int len_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_bit_serializer_skid.sv
// word_skid_reg: one-entry pending buffer holding a word and its length.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, clears valid
//   i_load : capture i_data/i_len and set valid
//   i_take : consumer removes the entry (clears valid)
//   i_data : word to store
//   i_len  : normalised length (1..WIDTH)
//   o_data : stored word
//   o_len  : stored length
//   o_vld  : entry present
module word_skid_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_take,
    input  logic [WIDTH-1:0] i_data,
    input  logic [LEN_W-1:0] i_len,
    output logic [WIDTH-1:0] o_data,
    output logic [LEN_W-1:0] o_len,
    output logic             o_vld
);

    logic [WIDTH-1:0] r_data;
    logic [LEN_W-1:0] r_len;
    logic             r_vld;

    // Load and take never coincide: the producer is blocked while the entry is full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_len  <= i_len;
        end else if (i_take) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_len  = r_len;
    assign o_vld  = r_vld;

endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: accepts parallel words over valid/ready and shifts them
// out MSB-first, one bit per clock, onto the detector X input. HOLD drives the
// detector EN so it only advances on cycles carrying a real bit.
//   clk        : clock, all logic on posedge
//   RST        : synchronous active-high reset
//   in_data    : word to serialize, MSB first
//   in_len     : valid bit count, MSB-aligned; 0 -> WIDTH, >WIDTH -> WIDTH
//   in_valid   : producer has a word
//   in_ready   : word accepted on this edge if in_valid
//   pause      : freeze serialization, current bit not consumed
//   X          : serial bit
//   HOLD       : 1 = no bit this cycle
//   busy       : active or pending word present
//   words_sent : count of fully sent words, wraps
module seq_bit_serializer
    import dsdo_pkg::*;
#(
    parameter int WIDTH = DSDO_WORD_W,
    parameter int LEN_W = len_w(WIDTH)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pause,
    output logic             X,
    output logic             HOLD,
    output logic             busy,
    output logic [15:0]      words_sent
);

    logic [WIDTH-1:0] r_act_sr;
    logic [LEN_W-1:0] r_act_cnt;
    logic             r_act_vld;
    logic [15:0]      r_words;

    logic [WIDTH-1:0] w_pend_data;
    logic [LEN_W-1:0] w_pend_len;
    logic             w_pend_vld;

    logic             w_xfer;
    logic             w_consume;
    logic             w_retire;
    logic             w_to_act;
    logic             w_pend_load;
    logic             w_pend_take;
    logic [LEN_W-1:0] w_norm_len;

    assign in_ready  = !w_pend_vld && !RST;
    assign w_xfer    = in_valid && in_ready;
    assign w_consume = r_act_vld && !pause;
    assign w_retire  = w_consume && (r_act_cnt == LEN_W'(1));

    // Stored length is always 1..WIDTH.
    assign w_norm_len = ((in_len == '0) || (in_len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : in_len;

    // Incoming word bypasses the pending slot when the active register is (or is about to be) free
    // and nothing older is waiting.
    assign w_to_act    = !r_act_vld || (w_retire && !w_pend_vld);
    assign w_pend_load = w_xfer && !w_to_act;
    assign w_pend_take = w_retire && w_pend_vld;

    word_skid_reg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_pend (
        .i_clk  (clk),
        .i_rst  (RST),
        .i_load (w_pend_load),
        .i_take (w_pend_take),
        .i_data (in_data),
        .i_len  (w_norm_len),
        .o_data (w_pend_data),
        .o_len  (w_pend_len),
        .o_vld  (w_pend_vld)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            r_act_vld <= 1'b0;
            r_act_sr  <= '0;
            r_act_cnt <= '0;
            r_words   <= '0;
        end else if (w_retire) begin
            r_words <= r_words + 16'd1;
            if (w_pend_vld) begin
                r_act_vld <= 1'b1;
                r_act_sr  <= w_pend_data;
                r_act_cnt <= w_pend_len;
            end else if (w_xfer) begin
                r_act_vld <= 1'b1;
                r_act_sr  <= in_data;
                r_act_cnt <= w_norm_len;
            end else begin
                r_act_vld <= 1'b0;
                r_act_sr  <= r_act_sr << 1;
                r_act_cnt <= '0;
            end
        end else if (!r_act_vld && w_xfer) begin
            r_act_vld <= 1'b1;
            r_act_sr  <= in_data;
            r_act_cnt <= w_norm_len;
        end else if (w_consume) begin
            r_act_sr  <= r_act_sr << 1;
            r_act_cnt <= r_act_cnt - LEN_W'(1);
        end
    end

    assign X          = r_act_sr[WIDTH-1];
    assign HOLD       = (!r_act_vld || pause) ? HOLD_ACTIVE : !HOLD_ACTIVE;
    assign busy       = r_act_vld || w_pend_vld;
    assign words_sent = r_words;

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;

    logic        clk;
    logic        RST;
    logic [7:0]  in_data;
    logic [3:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic        pause;
    logic        X;
    logic        HOLD;
    logic        busy;
    logic [15:0] words_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_words = 0;

    seq_bit_serializer #(
        .WIDTH (8),
        .LEN_W (4)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .in_data    (in_data),
        .in_len     (in_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pause      (pause),
        .X          (X),
        .HOLD       (HOLD),
        .busy       (busy),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        int         nbits;
        logic [7:0] bits;   // expected stream, first bit in [7]
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then set and outputs checked #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_hold"}, 32'(HOLD), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_words"}, 32'(words_sent), 32'(16'(exp_words)));
    endtask

    logic [13:0] b2b_bits;
    logic [10:0] p_pause, p_x, p_hold;

    initial begin
        vecs[0] = '{data: 8'b1000_1000, len: 4'd5,  nbits: 5, bits: 8'b1000_1000};
        vecs[1] = '{data: 8'hC3,        len: 4'd0,  nbits: 8, bits: 8'hC3};
        vecs[2] = '{data: 8'hC3,        len: 4'd15, nbits: 8, bits: 8'hC3};
        vecs[3] = '{data: 8'hA5,        len: 4'd1,  nbits: 1, bits: 8'h80};
        vecs[4] = '{data: 8'h5A,        len: 4'd8,  nbits: 8, bits: 8'h5A};
        vecs[5] = '{data: 8'h3C,        len: 4'd9,  nbits: 8, bits: 8'h3C};

        RST = 1'b1; in_data = '0; in_len = '0; in_valid = 1'b0; pause = 1'b0;

        // Reset held for two cycles.
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            chk("rst_hold", 32'(HOLD), 32'd1);
            chk("rst_x", 32'(X), 32'd0);
            chk("rst_ready", 32'(in_ready), 32'd0);
            chk("rst_words", 32'(words_sent), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        RST = 1'b0;
        #1;
        chk("rst_ready_after", 32'(in_ready), 32'd1);
        tick(); #1;
        chk("rst_ready_cycle_after", 32'(in_ready), 32'd1);
        chk_idle("post_rst");

        // Single words from the table.
        for (int v = 0; v < 6; v++) begin
            tick();
            in_valid = 1'b1; in_data = vecs[v].data; in_len = vecs[v].len;
            #1;
            chk("vec_ready", 32'(in_ready), 32'd1);
            chk("vec_pre_hold", 32'(HOLD), 32'd1);
            tick();
            in_valid = 1'b0;
            #1;
            for (int i = 0; i < vecs[v].nbits; i++) begin
                chk($sformatf("vec%0d_hold_b%0d", v, i), 32'(HOLD), 32'd0);
                chk($sformatf("vec%0d_x_b%0d", v, i), 32'(X), 32'(vecs[v].bits[7-i]));
                tick(); #1;
            end
            exp_words++;
            chk_idle($sformatf("vec%0d_end", v));
        end

        // Back-to-back: 0x33/len6 then 0xF0/len8, second word parks in pending.
        b2b_bits = 14'b00110011110000;
        tick();
        in_valid = 1'b1; in_data = 8'h33; in_len = 4'd6;
        #1;
        chk("b2b_ready0", 32'(in_ready), 32'd1);
        tick();
        in_data = 8'hF0; in_len = 4'd8;
        for (int i = 0; i < 14; i++) begin
            if (i == 1) in_valid = 1'b0;
            #1;
            chk($sformatf("b2b_hold_%0d", i), 32'(HOLD), 32'd0);
            chk($sformatf("b2b_x_%0d", i), 32'(X), 32'(b2b_bits[13-i]));
            chk($sformatf("b2b_ready_%0d", i), 32'(in_ready), (i >= 1 && i <= 5) ? 32'd0 : 32'd1);
            chk($sformatf("b2b_busy_%0d", i), 32'(busy), 32'd1);
            tick();
        end
        #1;
        exp_words += 2;
        chk_idle("b2b_end");

        // Pause for three cycles after the second bit of 0xA5.
        p_pause = 11'b00111000000;
        p_x     = 11'b10111100101;
        p_hold  = 11'b00111000000;
        tick();
        in_valid = 1'b1; in_data = 8'hA5; in_len = 4'd8;
        #1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            pause = p_pause[10-i];
            #1;
            chk($sformatf("pause_hold_%0d", i), 32'(HOLD), 32'(p_hold[10-i]));
            chk($sformatf("pause_x_%0d", i), 32'(X), 32'(p_x[10-i]));
            tick();
        end
        pause = 1'b0;
        #1;
        exp_words++;
        chk_idle("pause_end");

        // Pause over the last (only) bit: no retire, no count.
        tick();
        in_valid = 1'b1; in_data = 8'h80; in_len = 4'd1;
        #1;
        tick();
        in_valid = 1'b0;
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("lastp_hold", 32'(HOLD), 32'd1);
            chk("lastp_x", 32'(X), 32'd1);
            chk("lastp_busy", 32'(busy), 32'd1);
            chk("lastp_words", 32'(words_sent), 32'(16'(exp_words)));
            tick();
        end
        pause = 1'b0;
        #1;
        chk("lastp_release_hold", 32'(HOLD), 32'd0);
        chk("lastp_release_x", 32'(X), 32'd1);
        tick(); #1;
        exp_words++;
        chk_idle("lastp_end");

        // Reset mid-word with pending full: 0xFF active, 0x0F pending.
        tick();
        in_valid = 1'b1; in_data = 8'hFF; in_len = 4'd8;
        #1;
        tick();
        in_data = 8'h0F;
        #1;
        chk("rmid_x0", 32'(X), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("rmid_ready_pend", 32'(in_ready), 32'd0);
        chk("rmid_x1", 32'(X), 32'd1);
        tick(); #1;
        chk("rmid_x2", 32'(X), 32'd1);
        tick();
        RST = 1'b1;
        #1;
        chk("rmid_ready_rst", 32'(in_ready), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        chk("rmid_x_after", 32'(X), 32'd0);
        chk("rmid_ready_after", 32'(in_ready), 32'd1);
        exp_words = 0;
        for (int i = 0; i < 4; i++) begin
            chk_idle($sformatf("rmid_idle%0d", i));
            tick(); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
